lc3b_muldiv: RTL and testbench

Iterative, parametrised multiply/divide unit for the LC-3b execute stage, serving `alu_mult` and `alu_div` (`mult_op` / `div_op` in the control word). It computes one radix-2 step per clock, with a start/busy/done handshake so the pipeline can stall while it runs. It supports signed and unsigned modes, and adds a divide-by-zero fast path and a pipeline kill, neither of which the single-cycle ALU has.

---
 rtl/lc3b_muldiv_pkg.sv | 5 +
 rtl/lc3b_muldiv_step.sv | 32 +++
 rtl/lc3b_muldiv.sv | 129 ++++++++++++
 tb/tb_lc3b_muldiv.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/lc3b_muldiv_pkg.sv
// Shared types for the LC-3b iterative multiply/divide unit.
package lc3b_muldiv_pkg;
    typedef enum bit {md_mult, md_div} lc3b_muldiv_op;
    typedef enum logic [1:0] {MD_IDLE, MD_CALC, MD_FIX} lc3b_muldiv_state;
endpackage

// File: rtl/lc3b_muldiv_step.sv
// One radix-2 iteration over the {acc, q} pair: shift-add multiply or
// restoring shift-subtract divide, on unsigned magnitudes.
module lc3b_muldiv_step #(
    parameter int WIDTH = 16
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0] q_nxt
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem;
    logic           ge;

    always_comb begin
        sum     = {1'b0, acc} + (q[0] ? {1'b0, d} : '0);
        rem     = {acc, q[WIDTH-1]};
        ge      = rem >= {1'b0, d};
        acc_nxt = '0;
        q_nxt   = '0;
        if (is_div) begin
            // Trial subtract; keep the shifted partial remainder on borrow.
            acc_nxt = ge ? WIDTH'(rem - {1'b0, d}) : rem[WIDTH-1:0];
            q_nxt   = {q[WIDTH-2:0], ge};
        end else begin
            acc_nxt = sum[WIDTH:1];
            q_nxt   = {sum[0], q[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/lc3b_muldiv.sv
// Iterative signed/unsigned multiply/divide with start/busy/done handshake,
// divide-by-zero fast path and pipeline kill.
module lc3b_muldiv
    import lc3b_muldiv_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             kill,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    lc3b_muldiv_state state;
    lc3b_muldiv_op    op_r;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc, q, d;
    logic [WIDTH-1:0] acc_nxt, q_nxt;
    logic             sgn_a, sgn_b, dbz_r;

    logic [2*WIDTH-1:0] prod, prod_f;
    logic [WIDTH-1:0]   quot_f, rem_f;
    logic               neg;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
        return (s && v[WIDTH-1]) ? -v : v;
    endfunction

    lc3b_muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (op_r == md_div),
        .acc     (acc),
        .q       (q),
        .d       (d),
        .acc_nxt (acc_nxt),
        .q_nxt   (q_nxt)
    );

    // Sign fixup; sgn_* are already zero in unsigned mode.
    always_comb begin
        neg    = sgn_a ^ sgn_b;
        prod   = {acc, q};
        prod_f = neg ? -prod : prod;
        quot_f = neg ? -q : q;
        rem_f  = sgn_a ? -acc : acc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= MD_IDLE;
            op_r        <= md_mult;
            cnt         <= '0;
            acc         <= '0;
            q           <= '0;
            d           <= '0;
            sgn_a       <= 1'b0;
            sgn_b       <= 1'b0;
            dbz_r       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result_lo   <= '0;
            result_hi   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                MD_IDLE: if (start && !kill) begin
                    op_r  <= lc3b_muldiv_op'(op);
                    sgn_a <= is_signed & a[WIDTH-1];
                    sgn_b <= is_signed & b[WIDTH-1];
                    cnt   <= CW'(WIDTH - 1);
                    busy  <= 1'b1;
                    if (op && b == '0) begin
                        // Raw dividend and all-ones quotient go straight out in FIX.
                        dbz_r <= 1'b1;
                        acc   <= a;
                        q     <= '1;
                        state <= MD_FIX;
                    end else begin
                        dbz_r <= 1'b0;
                        acc   <= '0;
                        q     <= op ? mag(a, is_signed) : mag(b, is_signed);
                        d     <= op ? mag(b, is_signed) : mag(a, is_signed);
                        state <= MD_CALC;
                    end
                end
                MD_CALC: begin
                    if (kill) begin
                        busy  <= 1'b0;
                        state <= MD_IDLE;
                    end else begin
                        acc <= acc_nxt;
                        q   <= q_nxt;
                        cnt <= cnt - 1'b1;
                        if (cnt == '0) state <= MD_FIX;
                    end
                end
                MD_FIX: begin
                    busy  <= 1'b0;
                    state <= MD_IDLE;
                    if (!kill) begin
                        done        <= 1'b1;
                        div_by_zero <= dbz_r;
                        if (dbz_r) begin
                            result_lo <= q;
                            result_hi <= acc;
                        end else if (op_r == md_div) begin
                            result_lo <= quot_f;
                            result_hi <= rem_f;
                        end else begin
                            result_lo <= prod_f[WIDTH-1:0];
                            result_hi <= prod_f[2*WIDTH-1:WIDTH];
                        end
                    end
                end
                default: state <= MD_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lc3b_muldiv.sv
// Self-checking bench for lc3b_muldiv: directed vector table, random ops
// against an arithmetic reference model, and handshake/kill/reset sequences.
module tb_lc3b_muldiv;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, op = 1'b0, is_signed = 1'b0, kill = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        busy, done, div_by_zero;
    logic [15:0] result_lo, result_hi;

    int pass_cnt = 0;
    int total_cnt = 0;

    lc3b_muldiv #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .is_signed(is_signed),
        .a(a), .b(b), .kill(kill), .busy(busy), .done(done),
        .result_lo(result_lo), .result_hi(result_hi), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic        sgn;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] lo;
        logic [15:0] hi;
        logic        z;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference: plain integer arithmetic over 64-bit values.
    function automatic void model(input logic o, input logic s, input logic [15:0] x, input logic [15:0] y,
                                  output logic [15:0] lo, output logic [15:0] hi, output logic z);
        longint sx, sy, r;
        sx = s ? longint'($signed(x)) : longint'(x);
        sy = s ? longint'($signed(y)) : longint'(y);
        z  = 1'b0;
        if (!o) begin
            r  = sx * sy;
            lo = r[15:0];
            hi = r[31:16];
        end else if (y == 16'h0) begin
            lo = 16'hFFFF;
            hi = x;
            z  = 1'b1;
        end else begin
            r  = sx / sy;
            lo = r[15:0];
            r  = sx % sy;
            hi = r[15:0];
        end
    endfunction

    // Called #1 after a posedge; drives start for exactly one edge.
    task automatic issue(input logic o, input logic s, input logic [15:0] x, input logic [15:0] y);
        op = o; is_signed = s; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Called just after the start edge; lat counts the start cycle too.
    task automatic wait_done(output int lat, output bit busy_ok);
        lat = -1;
        busy_ok = 1'b1;
        for (int n = 0; n < 100; n++) begin
            if (done) begin
                lat = n + 1;
                return;
            end
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic run_check(input string nm, input logic o, input logic s, input logic [15:0] x,
                             input logic [15:0] y, input logic [15:0] elo, input logic [15:0] ehi,
                             input logic ez, input int elat);
        int lat;
        bit bok;
        issue(o, s, x, y);
        wait_done(lat, bok);
        chk({nm, ".lat"}, lat, elat);
        chk({nm, ".busy_run"}, bok, 1);
        chk({nm, ".busy_done"}, busy, 0);
        chk({nm, ".lo"}, result_lo, elo);
        chk({nm, ".hi"}, result_hi, ehi);
        chk({nm, ".dbz"}, div_by_zero, ez);
    endtask

    initial begin
        int lat, seen;
        bit bok;
        logic [15:0] mlo, mhi, x, y;
        logic mz, o, s;

        vecs[0] = '{1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 18};
        vecs[1] = '{1'b0, 1'b1, 16'hFFFD, 16'h0005, 16'hFFF1, 16'hFFFF, 1'b0, 18};
        vecs[2] = '{1'b1, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 18};
        vecs[3] = '{1'b1, 1'b0, 16'h0064, 16'h0000, 16'hFFFF, 16'h0064, 1'b1, 2};
        vecs[4] = '{1'b1, 1'b0, 16'h0006, 16'h0003, 16'h0002, 16'h0000, 1'b0, 18};
        vecs[5] = '{1'b1, 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 18};
        vecs[6] = '{1'b1, 1'b0, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 18};
        vecs[7] = '{1'b0, 1'b1, 16'h8000, 16'h8000, 16'h0000, 16'h4000, 1'b0, 18};
        vecs[8] = '{1'b1, 1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 18};
        vecs[9] = '{1'b1, 1'b1, 16'hFFF9, 16'h0000, 16'hFFFF, 16'hFFF9, 1'b1, 2};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.lo", result_lo, 0);
        chk("rst.hi", result_hi, 0);
        chk("rst.dbz", div_by_zero, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++)
            run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b,
                      vecs[i].lo, vecs[i].hi, vecs[i].z, vecs[i].lat);

        for (int i = 0; i < 60; i++) begin
            o = 1'($urandom_range(1));
            s = 1'($urandom_range(1));
            x = 16'($urandom);
            y = ($urandom_range(7) == 0) ? 16'h0 : 16'($urandom);
            if ($urandom_range(9) == 0) x = 16'h8000;
            model(o, s, x, y, mlo, mhi, mz);
            run_check($sformatf("rnd%0d", i), o, s, x, y, mlo, mhi, mz, (o && y == 0) ? 2 : 18);
        end

        // 7x6 with an ignored start while busy, then back-to-back start in done cycle.
        issue(1'b0, 1'b0, 16'd7, 16'd6);
        repeat (4) begin @(posedge clk); #1; end
        op = 1'b0; a = 16'd3; b = 16'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, bok);
        chk("busy_start.lat", lat, 18 - 5);
        chk("busy_start.lo", result_lo, 42);
        chk("busy_start.hi", result_hi, 0);
        issue(1'b0, 1'b0, 16'd5, 16'd9);
        wait_done(lat, bok);
        chk("b2b.lat", lat, 18);
        chk("b2b.lo", result_lo, 45);

        // Kill at cycle 9: no done, results retained.
        @(posedge clk); #1;
        issue(1'b0, 1'b0, 16'd11, 16'd3);
        repeat (8) begin @(posedge clk); #1; end
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        chk("kill.busy_next", busy, 0);
        seen = 0;
        repeat (30) begin
            if (done) seen++;
            @(posedge clk); #1;
        end
        chk("kill.no_done", seen, 0);
        chk("kill.lo", result_lo, 45);
        chk("kill.hi", result_hi, 0);

        // Kill overrides a simultaneous start in idle.
        op = 1'b0; a = 16'd2; b = 16'd2; start = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        chk("kill_start.busy", busy, 0);

        // Asynchronous reset mid-CALC.
        issue(1'b0, 1'b0, 16'hFFFF, 16'hFFFF);
        repeat (5) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        chk("arst.busy", busy, 0);
        chk("arst.done", done, 0);
        chk("arst.lo", result_lo, 0);
        chk("arst.hi", result_hi, 0);
        chk("arst.dbz", div_by_zero, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_check("post_rst", 1'b0, 1'b0, 16'd123, 16'd45, 16'h159F, 16'h0000, 1'b0, 18);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
